// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and edge-select constants for debounce_pulse.
package debounce_pkg;
    localparam logic [1:0] ST_IDLE_LO = 2'd0;
    localparam logic [1:0] ST_WAIT_HI = 2'd1;
    localparam logic [1:0] ST_IDLE_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;
endpackage

// File: rtl/debounce_pulse_sincronizador.sv
// sincronizador: multi-flop synchronizer bringing an async input into the clk domain.
module sincronizador #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
    assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/debounce_pulse.sv
// debounce_pulse: synchronizes and debounces a raw input into a clean level plus a one-cycle event pulse.
module debounce_pulse
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int EDGE        = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic din,
    output logic level,
    output logic pulse,
    output logic busy
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic          s;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          pulse_q, pulse_d;
    logic          hit, done, match;
    sincronizador #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (din),
        .q  (s)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE_LO;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end
    // state bit 1 is the accepted level, bit 0 marks a WAIT state; the target is the opposite level
    always_comb begin
        cnt_inc = cnt_q + CW'(1);
        hit     = ena && (s != state_q[1]);
        done    = hit && (state_q[0] ? (cnt_inc == CW'(DB_CYCLES)) : (DB_CYCLES == 1));
        state_d = done ? {~state_q[1], 1'b0} : {state_q[1], hit};
        cnt_d   = (hit && !done) ? cnt_inc : '0;
        match   = (EDGE == EDGE_RISE) ? done && !state_q[1] :
                  (EDGE == EDGE_FALL) ? done &&  state_q[1] : done;
        pulse_d = match && !pulse_q;
    end
    always_comb begin
        level = (state_q == ST_IDLE_HI) || (state_q == ST_WAIT_LO);
        busy  = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);
        pulse = pulse_q;
    end
endmodule
